// File: rtl/cmd_seq_pkg.sv
// Shared types for the command sequencer: FSM state encoding and the
// default-width {cmd, gap} queue entry.
package cmd_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int GAP_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] cmd;
    logic [GAP_W_DEF-1:0]  gap;
  } entry_t;

  function automatic entry_t mk_entry(input logic [DATA_W_DEF-1:0] cmd,
                                      input logic [GAP_W_DEF-1:0]  gap);
    entry_t e;
    e.cmd = cmd;
    e.gap = gap;
    return e;
  endfunction

endpackage

// File: rtl/cmd_seq_tx_if.sv
// Sequencer-to-UART-transmitter handshake.
// trmt is a one-cycle start strobe; tx_data is held stable from the trmt cycle
// until the transmitter reports tx_done, which is only honoured after trmt.
interface cmd_seq_tx_if #(parameter int DATA_W = 8);

  logic              trmt;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;

  modport master (output trmt, output tx_data, input tx_done);
  modport slave  (input trmt, input tx_data, output tx_done);

endinterface

// File: rtl/cmd_seq_tx_sync_fifo.sv
// Circular FIFO with extra-MSB pointers, show-ahead read and synchronous flush.
// full/empty/count are registered from the next-cycle pointer values.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt, diff_nxt;
  logic             do_push, do_pop;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push  = push & ~flush & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (do_push) wr_nxt = wr_ptr + PW'(1);
      if (do_pop)  rd_nxt = rd_ptr + PW'(1);
    end
    diff_nxt = wr_nxt - rd_nxt;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      count  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (diff_nxt == PW'(DEPTH));
      empty  <= (diff_nxt == '0);
      count  <= CW'(diff_nxt);
    end
  end

endmodule

// File: rtl/cmd_seq_tx.sv
// Queued command sequencer: pops {cmd, gap} entries, strobes the UART
// transmitter, waits for tx_done, then idles for the entry's gap.
module cmd_seq_tx
  import cmd_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int GAP_W  = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_cmd,
  input  logic [GAP_W-1:0]  wr_gap,
  input  logic              flush,
  input  logic              enable,
  cmd_seq_tx_if.master      tx,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic [15:0]       sent_cnt,
  output logic              ovf,
  output state_t            dbg_state
);

  state_t                    state_r, state_nxt;
  logic                      pop;
  logic [DATA_W+GAP_W-1:0]   head;
  logic [DATA_W-1:0]         tx_data_r;
  logic [GAP_W-1:0]          gap_r, gap_cnt;

  sync_fifo #(.WIDTH(DATA_W + GAP_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data ({wr_cmd, wr_gap}),
    .pop       (pop),
    .pop_data  (head),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt;
  end

  // tx_done is only looked at in WAIT, so a level left over from the
  // previous byte during SEND cannot complete the new one.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (enable && !empty) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (tx.tx_done) state_nxt = (gap_r == '0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx.trmt = (state_r == SEND);
    busy    = (state_r != IDLE);
    pop     = (state_r == IDLE) && enable && !empty;
  end

  assign tx.tx_data = tx_data_r;
  assign dbg_state  = state_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_r <= '0;
      gap_r     <= '0;
      gap_cnt   <= '0;
      sent_cnt  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (pop) begin
        tx_data_r <= head[DATA_W+GAP_W-1 -: DATA_W];
        gap_r     <= head[GAP_W-1:0];
      end
      if (state_r == WAIT && tx.tx_done) begin
        sent_cnt <= sent_cnt + 16'd1;
        gap_cnt  <= gap_r;
      end else if (state_r == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      // A flushed write is discarded on purpose and is not an overflow.
      if (wr_en && full && !pop && !flush) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_seq_tx.sv
// Bench for cmd_seq_tx: transmitter/receiver model, a FIFO-status vector
// table, and directed multi-cycle sequences for timing and control corners.
module tb_cmd_seq_tx;
  import cmd_seq_pkg::*;

  localparam int CLK_P  = 10;
  localparam int TX_LAT = 3;
  localparam int NV     = 11;

  logic        clk, rst;
  logic        wr_en, flush, enable;
  logic [7:0]  wr_cmd;
  logic [15:0] wr_gap;
  logic        full, empty, busy, ovf;
  logic [3:0]  count;
  logic [15:0] sent_cnt;
  state_t      dbg_state;
  logic        model_done, man_done, model_hold;

  int n_vec = 0;
  int n_bad = 0;

  cmd_seq_tx_if #(.DATA_W(8)) tx_if ();
  assign tx_if.tx_done = model_done | man_done;

  cmd_seq_tx #(.DATA_W(8), .DEPTH(8), .GAP_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_gap(wr_gap),
    .flush(flush), .enable(enable), .tx(tx_if.master), .full(full),
    .empty(empty), .count(count), .busy(busy), .sent_cnt(sent_cnt),
    .ovf(ovf), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #(CLK_P / 2) clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors, required completion", n_vec);
    $fatal(1, "watchdog");
  end

  // transmitter + receiver model, all observation on the falling edge
  logic [7:0] rx_q[$];
  longint     trmt_t[$];
  int         gap_cyc    = 0;
  int         proto_err  = 0;
  int         busy_cnt   = 0;
  logic [7:0] cur_byte   = 8'h00;
  logic       trmt_prev  = 1'b0;

  initial begin
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_if.trmt) begin
        trmt_t.push_back(longint'($time));
        if (trmt_prev) proto_err++;
      end
      trmt_prev = tx_if.trmt;
      if (dbg_state == GAP) gap_cyc++;
      model_done = 1'b0;
      if (busy_cnt > 0) begin
        if (tx_if.tx_data !== cur_byte) proto_err++;
        busy_cnt--;
        if (busy_cnt == 0) begin
          model_done = 1'b1;
          rx_q.push_back(cur_byte);
        end
      end else if (tx_if.trmt && !model_hold) begin
        cur_byte = tx_if.tx_data;
        busy_cnt = TX_LAT;
      end
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    rx_q.delete();
    trmt_t.delete();
    gap_cyc = 0;
  endtask

  // driver tasks
  task automatic push(input logic [7:0] c, input logic [15:0] g);
    entry_t e;
    e = mk_entry(c, g);
    wr_en  = 1'b1;
    wr_cmd = e.cmd;
    wr_gap = e.gap;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!(busy == 1'b0 && empty == 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_reached"}, 32'(n < budget), 32'd1);
    #1;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (dbg_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_state_reached"}, 32'(n < budget), 32'd1);
  endtask

  // FIFO-status vector table (enable held low, so nothing pops)
  typedef struct {
    logic       wr_en;
    logic [7:0] cmd;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    longint t_push;

    vecs[0]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'h10, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h11, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h12, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h13, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h14, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h15, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h16, 4'd7, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h17, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h18, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 4'd8, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_cmd = 8'h00; wr_gap = 16'd0;
    flush = 1'b0; enable = 1'b0; man_done = 1'b0; model_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset values
    check("rst_trmt", 32'(tx_if.trmt), 32'd0);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", 32'(sent_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // basic send of 8'hE8
    clear_log();
    enable = 1'b1;
    t_push = longint'($time);
    push(8'hE8, 16'd0);
    wait_idle(50, "basic");
    check("basic_trmt_pulses", 32'(trmt_t.size()), 32'd1);
    check("basic_latency", 32'((trmt_t[0] - t_push) / CLK_P), 32'd2);
    check("basic_rx_size", 32'(rx_q.size()), 32'd1);
    check("basic_rx_byte", 32'(rx_q[0]), 32'hE8);
    check("basic_sent", 32'(sent_cnt), 32'd1);

    // ordering and gaps: 47/100, 53/0, 52/5
    clear_log();
    enable = 1'b0;
    push(8'h47, 16'd100);
    push(8'h53, 16'd0);
    push(8'h52, 16'd5);
    enable = 1'b1;
    wait_idle(400, "order");
    check("order_rx_size", 32'(rx_q.size()), 32'd3);
    check("order_rx0", 32'(rx_q[0]), 32'h47);
    check("order_rx1", 32'(rx_q[1]), 32'h53);
    check("order_rx2", 32'(rx_q[2]), 32'h52);
    check("order_trmt_spacing_gap100", 32'((trmt_t[1] - trmt_t[0]) / CLK_P), 32'(TX_LAT + 100 + 2));
    check("order_trmt_spacing_gap0", 32'((trmt_t[2] - trmt_t[1]) / CLK_P), 32'(TX_LAT + 0 + 2));
    check("order_gap_cycles", 32'(gap_cyc), 32'd105);
    check("order_sent", 32'(sent_cnt), 32'd4);

    // overflow table: 9 pushes into 8 entries with enable low
    enable = 1'b0;
    for (int i = 0; i < NV; i++) begin
      wr_en  = vecs[i].wr_en;
      wr_cmd = vecs[i].cmd;
      wr_gap = 16'd0;
      @(negedge clk);
      wr_en = 1'b0;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
    end

    // drain: exactly the first 8 come out, the dropped 9th never does
    clear_log();
    enable = 1'b1;
    wait_idle(300, "drain");
    check("drain_rx_size", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("drain_rx%0d", i), 32'(rx_q[i]), 32'(8'h10 + i));
    check("drain_sent", 32'(sent_cnt), 32'd12);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);

    // write into a full FIFO in the pop cycle
    enable = 1'b0;
    do_reset();
    clear_log();
    for (int i = 0; i < 8; i++) push(8'(8'hD0 + i), 16'd0);
    check("fullpop_pre_count", 32'(count), 32'd8);
    check("fullpop_pre_full", 32'(full), 32'd1);
    enable = 1'b1; wr_en = 1'b1; wr_cmd = 8'hDF; wr_gap = 16'd0;
    @(negedge clk);
    wr_en = 1'b0;
    check("fullpop_count", 32'(count), 32'd8);
    check("fullpop_ovf", 32'(ovf), 32'd0);
    check("fullpop_busy", 32'(busy), 32'd1);
    wait_idle(300, "fullpop");
    check("fullpop_rx_size", 32'(rx_q.size()), 32'd9);
    check("fullpop_rx_first", 32'(rx_q[0]), 32'hD0);
    check("fullpop_rx_last", 32'(rx_q[8]), 32'hDF);
    check("fullpop_sent", 32'(sent_cnt), 32'd9);
    check("fullpop_ovf_end", 32'(ovf), 32'd0);

    // flush during the first command's WAIT
    enable = 1'b0;
    do_reset();
    clear_log();
    push(8'hA0, 16'd0);
    push(8'hA1, 16'd0);
    push(8'hA2, 16'd0);
    push(8'hA3, 16'd0);
    enable = 1'b1;
    wait_state(WAIT, 20, "flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    wait_idle(50, "flush");
    check("flush_trmt_pulses", 32'(trmt_t.size()), 32'd1);
    check("flush_rx0", 32'(rx_q[0]), 32'hA0);
    check("flush_sent", 32'(sent_cnt), 32'd1);

    // flush beats a same-cycle write, without flagging overflow
    flush = 1'b1; wr_en = 1'b1; wr_cmd = 8'hEE; wr_gap = 16'd0;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    check("flushwr_count", 32'(count), 32'd0);
    check("flushwr_empty", 32'(empty), 32'd1);
    check("flushwr_ovf", 32'(ovf), 32'd0);

    // pause: enable dropped during the first command's gap
    clear_log();
    enable = 1'b0;
    push(8'hB0, 16'd20);
    push(8'hB1, 16'd0);
    enable = 1'b1;
    wait_state(GAP, 30, "pause");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("pause_trmt_pulses", 32'(trmt_t.size()), 32'd1);
    check("pause_sent", 32'(sent_cnt), 32'd2);
    check("pause_count", 32'(count), 32'd1);
    check("pause_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_idle(50, "resume");
    check("resume_trmt_pulses", 32'(trmt_t.size()), 32'd2);
    check("resume_rx1", 32'(rx_q[1]), 32'hB1);
    check("resume_sent", 32'(sent_cnt), 32'd3);

    // reset while waiting on tx_done, then a late tx_done
    clear_log();
    model_hold = 1'b1;
    push(8'hC0, 16'd0);
    wait_state(WAIT, 20, "rstwait");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    check("rstwait_trmt", 32'(tx_if.trmt), 32'd0);
    check("rstwait_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rstwait_count", 32'(count), 32'd0);
    check("rstwait_empty", 32'(empty), 32'd1);
    check("rstwait_full", 32'(full), 32'd0);
    check("rstwait_busy", 32'(busy), 32'd0);
    check("rstwait_sent", 32'(sent_cnt), 32'd0);
    check("rstwait_ovf", 32'(ovf), 32'd0);
    man_done = 1'b1;
    repeat (3) @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check("late_done_sent", 32'(sent_cnt), 32'd0);
    check("late_done_busy", 32'(busy), 32'd0);

    check("tx_protocol_errors", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
